// File: rtl/weight_seq_ctrl.sv
// weight_seq_ctrl: streams weight-memory address pairs and serialises updates.
// Define WSEQ_ABORT_EN to add an abort input that cancels a running sweep.
module weight_seq_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef WSEQ_ABORT_EN
    input  logic                  abort,
`endif
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  upd_req,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic [DATA_WIDTH-1:0] upd_data,
    output logic                  upd_ack,
    output logic                  upd_err,
    output logic [ADDR_WIDTH-1:0] mem_read_addr_1,
    output logic [ADDR_WIDTH-1:0] mem_read_addr_2,
    input  logic [DATA_WIDTH-1:0] mem_read_data_1,
    input  logic [DATA_WIDTH-1:0] mem_read_data_2,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic [DATA_WIDTH-1:0] pair_w1,
    output logic [DATA_WIDTH-1:0] pair_w2,
    output logic                  pair_last
);

    localparam int            IW  = ADDR_WIDTH + 1;
    localparam logic [IW-1:0] DEP = IW'(DEPTH);
    localparam logic [IW-1:0] ONE = IW'(1);
    localparam logic [IW-1:0] TWO = IW'(2);

    typedef enum logic [1:0] {IDLE, WR, SWEEP} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] w1_q, w1_d, w2_q, w2_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;

    logic [IW-1:0] fetch, fetch1;
    logic          fetch_ok, fetch1_ok, upd_ok, go, capture, abort_i;

    // Read port always points at the pair that would be captured this edge
    assign fetch     = (state_q == SWEEP) ? idx_q + TWO : '0;
    assign fetch1    = fetch + ONE;
    assign fetch_ok  = fetch < DEP;
    assign fetch1_ok = fetch1 < DEP;
    assign upd_ok    = {1'b0, upd_addr} < DEP;
    assign go        = pend_q | start;

`ifdef WSEQ_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign mem_read_addr_1 = fetch_ok ? fetch[ADDR_WIDTH-1:0] : '0;
    assign mem_read_addr_2 = fetch1_ok ? fetch1[ADDR_WIDTH-1:0] : '0;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q | start;
        valid_d = valid_q;
        last_d  = last_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (upd_req) begin
                    state_d = WR;
                    ack_d   = 1'b1;
                    err_d   = !upd_ok;
                    we_d    = upd_ok;
                    wa_d    = upd_addr;
                    wd_d    = upd_data;
                end else if (go) begin
                    capture = 1'b1;
                    pend_d  = 1'b0;
                    state_d = SWEEP;
                end
            end
            WR: begin
                // Write commits at the negedge, so a sweep may read it at once
                if (go) begin
                    capture = 1'b1;
                    pend_d  = 1'b0;
                    state_d = SWEEP;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if (abort_i) begin
                    valid_d = 1'b0;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                    state_d = IDLE;
                end else if (valid_q && pair_ready) begin
                    if (!last_q) begin
                        capture = 1'b1;
                        idx_d   = fetch;
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            valid_d = 1'b1;
            w1_d    = mem_read_data_1;
            w2_d    = fetch1_ok ? mem_read_data_2 : '0;
            last_d  = (fetch + TWO) >= DEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            w1_q    <= '0;
            w2_q    <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    assign busy           = (state_q != IDLE) | pend_q;
    assign done           = done_q;
    assign upd_ack        = ack_q;
    assign upd_err        = err_q;
    assign mem_write_en   = we_q;
    assign mem_write_addr = wa_q;
    assign mem_write_data = wd_q;
    assign pair_valid     = valid_q;
    assign pair_w1        = w1_q;
    assign pair_w2        = w2_q;
    assign pair_last      = last_q;

endmodule
